ecc_check_encoder: RTL and testbench

- Upstream stage of the 32-bit single-error-correcting decoder. Accepts 32-bit data words and generates the 8 check bits that the decoder consumes on its id_ic0..id_ic7 inputs.
- Check-bit equations are chosen so that the downstream syndrome is zero for an uncorrupted word with the decoder's id_r=1.
- Two-stage valid/ready pipeline with full backpressure, plus an encoded-word counter.

---
 rtl/ecc_check_encoder_if.sv | 31 +++
 rtl/ecc_check_encoder.sv | 130 +++++++++++++
 tb/tb_ecc_check_encoder.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ecc_check_encoder_if.sv
// Valid/ready bus between the data source, the check-bit encoder and the SEC decoder.
// master drives words in and takes codewords out; slave is the encoder side.
interface ecc_check_encoder_if;
  logic        id_in_valid;
  logic        id_in_ready;
  logic [31:0] id_din;
  logic        id_out_valid;
  logic        id_out_ready;
  logic [31:0] id_dout;
  logic [7:0]  id_cout;

  modport master (
    output id_in_valid,
    output id_din,
    output id_out_ready,
    input  id_in_ready,
    input  id_out_valid,
    input  id_dout,
    input  id_cout
  );

  modport slave (
    input  id_in_valid,
    input  id_din,
    input  id_out_ready,
    output id_in_ready,
    output id_out_valid,
    output id_dout,
    output id_cout
  );
endinterface

// File: rtl/ecc_check_encoder.sv
// Two-stage check-bit encoder feeding the 32-bit SEC decoder, with handoff counter.
// Optional ECC_ERR_INJECT_EN adds a one-shot single-bit error injector.
module ecc_check_encoder #(
  parameter int CNT_W   = 16,
  parameter int CNT_SAT = 0
) (
  input  logic             id_clk,
  input  logic             id_rst,
  ecc_check_encoder_if.slave bus,
  output logic [CNT_W-1:0] id_cnt
`ifdef ECC_ERR_INJECT_EN
  ,
  input  logic             id_inj_req,
  input  logic [5:0]       id_inj_sel,
  output logic             id_inj_done
`endif
);

  localparam bit SAT = (CNT_SAT != 0);

  logic        s1_valid;
  logic [31:0] s1_data;
  logic        s2_adv;
  logic        out_hs;
  logic [7:0]  f;
  logic [7:0]  g;
  logic [7:0]  x;
  logic [7:0]  c;
  logic [31:0] enc_d;
  logic [7:0]  enc_c;

  assign s2_adv = s1_valid & (~bus.id_out_valid | bus.id_out_ready);
  assign out_hs = bus.id_out_valid & bus.id_out_ready;
  assign bus.id_in_ready = ~id_rst & (~s1_valid | s2_adv);

  // Nibble parities, pairwise mixed, then crossed with column parities.
  always_comb begin
    f = '0;
    x = '0;
    for (int i = 0; i < 8; i++) begin
      f[i] = ^s1_data[4*i +: 4];
    end
    for (int j = 0; j < 4; j++) begin
      x[j]   = s1_data[j]    ^ s1_data[j+4]
             ^ s1_data[j+8]  ^ s1_data[j+12];
      x[j+4] = s1_data[j+16] ^ s1_data[j+20]
             ^ s1_data[j+24] ^ s1_data[j+28];
    end
    g[0] = f[0] ^ f[1];
    g[1] = f[2] ^ f[3];
    g[2] = f[0] ^ f[2];
    g[3] = f[1] ^ f[3];
    g[4] = f[4] ^ f[5];
    g[5] = f[6] ^ f[7];
    g[6] = f[4] ^ f[6];
    g[7] = f[5] ^ f[7];
    c = x ^ {g[3:0], g[7:4]};
  end

`ifdef ECC_ERR_INJECT_EN
  logic        inj_pend;
  logic [5:0]  inj_sel_q;
  logic [39:0] flip;
  logic        fire;

  // Selects 40..63 shift the one out of range and flip nothing.
  assign flip  = inj_pend ? (40'd1 << inj_sel_q) : '0;
  assign fire  = s2_adv & inj_pend;
  assign enc_d = s1_data ^ flip[31:0];
  assign enc_c = c ^ flip[39:32];

  always_ff @(posedge id_clk) begin
    if (id_rst) begin
      inj_pend    <= 1'b0;
      inj_sel_q   <= '0;
      id_inj_done <= 1'b0;
    end else begin
      id_inj_done <= fire;
      if (id_inj_req) begin
        inj_pend  <= 1'b1;
        inj_sel_q <= id_inj_sel;
      end else if (fire) begin
        inj_pend  <= 1'b0;
      end
    end
  end
`else
  assign enc_d = s1_data;
  assign enc_c = c;
`endif

  always_ff @(posedge id_clk) begin
    if (id_rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (bus.id_in_valid & bus.id_in_ready) begin
      s1_valid <= 1'b1;
      s1_data  <= bus.id_din;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge id_clk) begin
    if (id_rst) begin
      bus.id_out_valid <= 1'b0;
      bus.id_dout      <= '0;
      bus.id_cout      <= '0;
    end else if (s2_adv) begin
      bus.id_out_valid <= 1'b1;
      bus.id_dout      <= enc_d;
      bus.id_cout      <= enc_c;
    end else if (out_hs) begin
      bus.id_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge id_clk) begin
    if (id_rst) begin
      id_cnt <= '0;
    end else if (out_hs) begin
      if (&id_cnt) begin
        id_cnt <= SAT ? id_cnt : '0;
      end else begin
        id_cnt <= id_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ecc_check_encoder.sv
// Randomized and directed bench for ecc_check_encoder against a
// capacity-2 queue model with check bits computed from the parity rules.
module tb_ecc_check_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] din;
  logic        out_ready;
  logic [15:0] cnt;
  logic [3:0]  cnt_w;
  logic [3:0]  cnt_s;

  always #5 clk = ~clk;

  ecc_check_encoder_if bus ();
  ecc_check_encoder_if bus_w ();
  ecc_check_encoder_if bus_s ();

  assign bus.id_in_valid    = in_valid;
  assign bus.id_din         = din;
  assign bus.id_out_ready   = out_ready;
  assign bus_w.id_in_valid  = in_valid;
  assign bus_w.id_din       = din;
  assign bus_w.id_out_ready = out_ready;
  assign bus_s.id_in_valid  = in_valid;
  assign bus_s.id_din       = din;
  assign bus_s.id_out_ready = out_ready;

`ifdef ECC_ERR_INJECT_EN
  logic       inj_req;
  logic [5:0] inj_sel;
  logic       inj_done;
  logic       inj_done_w;
  logic       inj_done_s;
`endif

  ecc_check_encoder u_dut (
    .id_clk (clk),
    .id_rst (rst),
    .bus    (bus.slave),
    .id_cnt (cnt)
`ifdef ECC_ERR_INJECT_EN
    ,
    .id_inj_req  (inj_req),
    .id_inj_sel  (inj_sel),
    .id_inj_done (inj_done)
`endif
  );

  ecc_check_encoder #(.CNT_W(4), .CNT_SAT(0)) u_wrap (
    .id_clk (clk),
    .id_rst (rst),
    .bus    (bus_w.slave),
    .id_cnt (cnt_w)
`ifdef ECC_ERR_INJECT_EN
    ,
    .id_inj_req  (inj_req),
    .id_inj_sel  (inj_sel),
    .id_inj_done (inj_done_w)
`endif
  );

  ecc_check_encoder #(.CNT_W(4), .CNT_SAT(1)) u_sat (
    .id_clk (clk),
    .id_rst (rst),
    .bus    (bus_s.slave),
    .id_cnt (cnt_s)
`ifdef ECC_ERR_INJECT_EN
    ,
    .id_inj_req  (inj_req),
    .id_inj_sel  (inj_sel),
    .id_inj_done (inj_done_s)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_cout(input logic [31:0] d);
    bit f [8];
    bit g [8];
    bit x [8];
    int ga [8] = '{0, 2, 0, 1, 4, 6, 4, 5};
    int gb [8] = '{1, 3, 2, 3, 5, 7, 6, 7};
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      f[i] = d[4*i] ^ d[4*i+1] ^ d[4*i+2] ^ d[4*i+3];
    end
    for (int i = 0; i < 8; i++) g[i] = f[ga[i]] ^ f[gb[i]];
    for (int j = 0; j < 8; j++) begin
      int b;
      b = (j < 4) ? j : j + 12;
      x[j] = d[b] ^ d[b+4] ^ d[b+8] ^ d[b+12];
    end
    for (int k = 0; k < 8; k++) r[k] = x[k] ^ g[(k+4)%8];
    return r;
  endfunction

  typedef struct {
    logic [31:0] d;
    logic [7:0]  c;
    int          age;
  } ent_t;

  ent_t        q [$];
  logic [7:0]  seen_c [$];
  logic [31:0] seen_d [$];
  int          cnt_tot = 0;
  bit          rst_edge = 1'b1;
  bit          mon_en = 1'b0;
  bit          inj_pend_m = 1'b0;
  int          inj_sel_m = 0;
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      int  n;
      bit  ov;
      bit  ir;
      ent_t e;
      n  = q.size();
      ov = (n > 0) && (q[0].age >= 1);
      ir = !rst && ((n < 2) || out_ready);
      chk("in_ready", bus.id_in_ready, ir);
      chk("out_valid", bus.id_out_valid, ov);
      if (ov) begin
        chk("dout", bus.id_dout, q[0].d);
        chk("cout", bus.id_cout, q[0].c);
      end
      if (rst_edge) begin
        chk("dout_rst", bus.id_dout, 0);
        chk("cout_rst", bus.id_cout, 0);
      end
      chk("cnt", cnt, cnt_tot % 65536);
      chk("cnt_wrap4", cnt_w, cnt_tot % 16);
      chk("cnt_sat4", cnt_s, (cnt_tot > 15) ? 15 : cnt_tot);
`ifdef ECC_ERR_INJECT_EN
      if (inj_done) done_cnt++;
`endif
      if (rst) begin
        q.delete();
        cnt_tot    = 0;
        rst_edge   = 1'b1;
        inj_pend_m = 1'b0;
      end else begin
        rst_edge = 1'b0;
        if (ov && out_ready) begin
          seen_c.push_back(bus.id_cout);
          seen_d.push_back(bus.id_dout);
          void'(q.pop_front());
          cnt_tot++;
        end
        foreach (q[i]) q[i].age++;
        if (in_valid && ir) begin
          e.d   = din;
          e.c   = ref_cout(din);
          e.age = 0;
          if (inj_pend_m) begin
            if (inj_sel_m < 32) e.d[inj_sel_m] = ~e.d[inj_sel_m];
            else if (inj_sel_m < 40) e.c[inj_sel_m-32] = ~e.c[inj_sel_m-32];
            inj_pend_m = 1'b0;
          end
          q.push_back(e);
        end
`ifdef ECC_ERR_INJECT_EN
        if (inj_req) begin
          inj_pend_m = 1'b1;
          inj_sel_m  = inj_sel;
        end
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic send(input logic [31:0] w);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    din = w;
    for (int i = 0; i < 32 && !ok; i++) begin
      @(negedge clk);
      ok = bus.id_in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    in_valid = 1'b0;
    din = '0;
    out_ready = 1'b0;
`ifdef ECC_ERR_INJECT_EN
    inj_req = 1'b0;
    inj_sel = '0;
`endif
    step();
    mon_en = 1'b1;
    step();
    rst = 1'b0;

    out_ready = 1'b1;
    send(32'h0000_0000);
    idle(3);
    chk("t1_cnt", cnt, 1);
    chk("t1_cout", seen_c[seen_c.size()-1], 8'h00);

    do_reset();
    send(32'h0000_0001);
    send(32'h8000_0000);
    send(32'hFFFF_FFFF);
    idle(3);
    k = seen_c.size();
    chk("t2_c0", seen_c[k-3], 8'h51);
    chk("t2_c1", seen_c[k-2], 8'h8A);
    chk("t2_c2", seen_c[k-1], 8'h00);
    chk("t2_cnt", cnt, 3);

    out_ready = 1'b0;
    send(32'h1234_5678);
    send(32'h9ABC_DEF0);
    in_valid = 1'b1;
    din = 32'h0F0F_0F0F;
    repeat (3) step();
    chk("t3_stall", bus.id_in_ready, 0);
    out_ready = 1'b1;
    send(32'h0F0F_0F0F);
    send(32'hDEAD_BEEF);
    idle(4);
    k = seen_d.size();
    chk("t3_d3", seen_d[k-1], 32'hDEAD_BEEF);
    chk("t3_cnt", cnt, 7);

    out_ready = 1'b0;
    send(32'hAAAA_5555);
    send(32'h5555_AAAA);
    do_reset();
    out_ready = 1'b1;
    idle(4);
    chk("t4_cnt", cnt, 0);

    for (int i = 0; i < 17; i++) send($urandom);
    idle(4);
    chk("t5_wrap", cnt_w, 1);
    chk("t5_sat", cnt_s, 15);
    chk("t5_cnt", cnt, 17);

`ifdef ECC_ERR_INJECT_EN
    do_reset();
    done_cnt = 0;
    inj_sel = 6'd5;
    inj_req = 1'b1;
    step();
    inj_req = 1'b0;
    send(32'h0000_0000);
    send(32'h0000_0000);
    idle(4);
    k = seen_d.size();
    chk("inj_dout", seen_d[k-2], 32'h0000_0020);
    chk("inj_cout", seen_c[k-2], 8'h00);
    chk("inj_next", seen_d[k-1], 32'h0000_0000);
    chk("inj_done", done_cnt, 1);
`endif

    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      din       = $urandom;
      out_ready = ($urandom_range(2) != 0);
      rst       = ($urandom_range(199) == 0);
      step();
    end
    rst = 1'b0;
    out_ready = 1'b1;
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
